// File: rtl/lfsr5_pkg.sv
// rtl/lfsr5_pkg.sv - shared LFSR width, seed, next-state function and checker states
package lfsr5_pkg;

  localparam int LFSR_W = 5;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 5'h1f;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } chk_state_t;

  // Generator next-state; the all-zero word is a fixed point (lockup).
  function automatic logic [LFSR_W-1:0] lfsr5_next(input logic [LFSR_W-1:0] d);
    logic [LFSR_W-1:0] n;
    n[4] = d[4] ^ d[1];
    n[3] = d[3] ^ d[0];
    n[2] = d[2] ^ n[4];
    n[1] = d[1] ^ n[3];
    n[0] = d[0] ^ n[2];
    return n;
  endfunction

endpackage

// File: rtl/lfsr5_checker.sv
// rtl/lfsr5_checker.sv - locks onto a 5-bit LFSR stream, then flywheels and counts mismatches
module lfsr5_checker
  import lfsr5_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int ERR_W    = 16
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              in_valid,
  input  logic [LFSR_W-1:0] in_data,
  input  logic              clr_errs,
  output logic              locked,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_count,
  output logic [LFSR_W-1:0] expected
);

  localparam int MCW = $clog2(LOCK_CNT + 1);
  localparam int XCW = $clog2(LOSS_CNT + 1);

  chk_state_t        state_q, state_d;
  logic [LFSR_W-1:0] prev_q, prev_d;
  logic              prev_ok_q, prev_ok_d;
  logic [MCW-1:0]    match_cnt_q, match_cnt_d;
  logic [XCW-1:0]    miss_cnt_q, miss_cnt_d;
  logic              locked_q, locked_d;
  logic              err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0]  err_count_q, err_count_d;
  logic [LFSR_W-1:0] expected_q, expected_d;

  // State register; reset returns everything to the hunting state immediately.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= HUNT;
      prev_q      <= '0;
      prev_ok_q   <= 1'b0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
      expected_q  <= LFSR_SEED;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      prev_ok_q   <= prev_ok_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
      expected_q  <= expected_d;
    end
  end

  // Next-state: hunt for LOCK_CNT consecutive good transitions, then free-run the prediction.
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    prev_ok_d   = prev_ok_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    locked_d    = locked_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;
    expected_d  = expected_q;

    if (in_valid) begin
      unique case (state_q)
        HUNT: begin
          prev_d    = in_data;
          prev_ok_d = 1'b1;
          if (prev_ok_q && (in_data == lfsr5_next(prev_q)) && (in_data != '0)) begin
            if (match_cnt_q == MCW'(LOCK_CNT - 1)) begin
              state_d     = LOCKED;
              locked_d    = 1'b1;
              expected_d  = lfsr5_next(in_data);
              miss_cnt_d  = '0;
              match_cnt_d = '0;
            end else begin
              match_cnt_d = match_cnt_q + MCW'(1);
            end
          end else begin
            match_cnt_d = '0;
          end
        end
        LOCKED: begin
          expected_d = lfsr5_next(expected_q);
          if (in_data == expected_q) begin
            miss_cnt_d = '0;
          end else begin
            err_pulse_d = 1'b1;
            if (err_count_q != '1) begin
              err_count_d = err_count_q + ERR_W'(1);
            end
            if (miss_cnt_q == XCW'(LOSS_CNT - 1)) begin
              state_d     = HUNT;
              locked_d    = 1'b0;
              match_cnt_d = '0;
              prev_ok_d   = 1'b0;
              miss_cnt_d  = '0;
            end else begin
              miss_cnt_d = miss_cnt_q + XCW'(1);
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end

    // Clearing wins over a same-cycle increment.
    if (clr_errs) begin
      err_count_d = '0;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
  assign expected  = expected_q;

endmodule

// File: tb/tb_lfsr5_checker.sv
// tb/tb_lfsr5_checker.sv - directed plus randomized checks of lfsr5_checker against a reference model
module tb_lfsr5_checker;
  import lfsr5_pkg::*;

  localparam int LOCK = 4;
  localparam int LOSS = 3;
  localparam int EW   = 16;

  logic           clk = 1'b0;
  logic           nreset;
  logic           in_valid;
  logic [4:0]     in_data;
  logic           clr_errs;
  logic           locked;
  logic           err_pulse;
  logic [EW-1:0]  err_count;
  logic [4:0]     expected;

  logic           v2;
  logic [4:0]     d2;
  logic           c2;
  logic           locked2;
  logic           err_pulse2;
  logic [1:0]     err_count2;
  logic [4:0]     expected2;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic        m_locked;
  logic [4:0]  m_prev;
  logic        m_prev_ok;
  int          m_match;
  int          m_miss;
  int          m_err;
  logic [4:0]  m_exp;
  logic        m_pulse;

  lfsr5_checker #(.LOCK_CNT(LOCK), .LOSS_CNT(LOSS), .ERR_W(EW)) dut (
    .clk(clk), .nreset(nreset), .in_valid(in_valid), .in_data(in_data),
    .clr_errs(clr_errs), .locked(locked), .err_pulse(err_pulse),
    .err_count(err_count), .expected(expected)
  );

  lfsr5_checker #(.LOCK_CNT(4), .LOSS_CNT(8), .ERR_W(2)) dut_sat (
    .clk(clk), .nreset(nreset), .in_valid(v2), .in_data(d2),
    .clr_errs(c2), .locked(locked2), .err_pulse(err_pulse2),
    .err_count(err_count2), .expected(expected2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0; m_prev = '0; m_prev_ok = 1'b0; m_match = 0;
    m_miss = 0; m_err = 0; m_exp = LFSR_SEED; m_pulse = 1'b0;
  endtask

  task automatic model_sample(input logic v, input logic [4:0] d, input logic c);
    m_pulse = 1'b0;
    if (v) begin
      if (!m_locked) begin
        if (m_prev_ok && d == lfsr5_next(m_prev) && d != 5'h00) m_match++;
        else m_match = 0;
        m_prev = d;
        m_prev_ok = 1'b1;
        if (m_match == LOCK) begin
          m_locked = 1'b1; m_exp = lfsr5_next(d); m_miss = 0; m_match = 0;
        end
      end else begin
        if (d != m_exp) begin
          m_pulse = 1'b1;
          if (m_err < (1 << EW) - 1) m_err++;
          m_miss++;
          if (m_miss == LOSS) begin
            m_locked = 1'b0; m_match = 0; m_prev_ok = 1'b0; m_miss = 0;
          end
        end else begin
          m_miss = 0;
        end
        m_exp = lfsr5_next(m_exp);
      end
    end
    if (c) m_err = 0;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".locked"}, 32'(locked), 32'(m_locked));
    chk({tag, ".err_pulse"}, 32'(err_pulse), 32'(m_pulse));
    chk({tag, ".err_count"}, 32'(err_count), 32'(m_err));
    if (m_locked) chk({tag, ".expected"}, 32'(expected), 32'(m_exp));
  endtask

  // Called at a negedge; drives, clocks, then samples on the next negedge.
  task automatic step(input logic v, input logic [4:0] d, input logic c, input string tag);
    in_valid = v; in_data = d; clr_errs = c;
    @(posedge clk);
    model_sample(v, d, c);
    @(negedge clk);
    in_valid = 1'b0; clr_errs = 1'b0;
    compare_all(tag);
  endtask

  task automatic step2(input logic [4:0] d, input logic c);
    v2 = 1'b1; d2 = d; c2 = c;
    @(posedge clk);
    @(negedge clk);
    v2 = 1'b0; c2 = 1'b0;
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
  endtask

  task automatic lock_seq(input string tag);
    logic [4:0] w;
    w = LFSR_SEED;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, w, 1'b0, tag);
      w = lfsr5_next(w);
    end
  endtask

  initial begin
    logic [4:0] g;
    int pulses;
    nreset = 1'b0; in_valid = 1'b0; in_data = '0; clr_errs = 1'b0;
    v2 = 1'b0; d2 = '0; c2 = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst.locked", 32'(locked), 32'd0);
    chk("rst.err_pulse", 32'(err_pulse), 32'd0);
    chk("rst.err_count", 32'(err_count), 32'd0);
    chk("rst.expected", 32'(expected), 32'h1f);

    // Saturation and clear on the narrow-counter instance
    g = LFSR_SEED;
    for (int i = 0; i < 5; i++) begin
      step2(g, 1'b0);
      g = lfsr5_next(g);
    end
    chk("sat.locked", 32'(locked2), 32'd1);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step2(5'h00, 1'b0);
      if (err_pulse2) pulses++;
    end
    chk("sat.pulses", 32'(pulses), 32'd5);
    chk("sat.count", 32'(err_count2), 32'd3);
    chk("sat.still_locked", 32'(locked2), 32'd1);
    step2(5'h00, 1'b1);
    chk("sat.clr_pulse", 32'(err_pulse2), 32'd1);
    chk("sat.clr_count", 32'(err_count2), 32'd0);

    // Clean lock
    lock_seq("lock");
    chk("lock.locked", 32'(locked), 32'd1);
    chk("lock.expected", 32'(expected), 32'h0c);

    // Single error then recovery
    step(1'b1, 5'h00, 1'b0, "single0");
    chk("single.pulse", 32'(err_pulse), 32'd1);
    step(1'b1, 5'h0f, 1'b0, "single1");
    chk("single.pulse_off", 32'(err_pulse), 32'd0);
    chk("single.count", 32'(err_count), 32'd1);
    chk("single.expected", 32'(expected), 32'(lfsr5_next(5'h0f)));

    // Loss of lock after three misses, then relock
    for (int i = 0; i < 3; i++) step(1'b1, 5'h1f, 1'b0, "loss");
    chk("loss.locked", 32'(locked), 32'd0);
    chk("loss.count", 32'(err_count), 32'd4);
    lock_seq("relock");
    chk("relock.locked", 32'(locked), 32'd1);

    // Valid gaps in HUNT
    do_reset();
    g = LFSR_SEED;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, g, 1'b0, "gap");
      g = lfsr5_next(g);
      step(1'b0, 5'h00, 1'b0, "gap_idle");
      step(1'b0, 5'h15, 1'b0, "gap_idle");
    end
    chk("gap.locked", 32'(locked), 32'd1);

    // Lockup word stream never locks
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 5'h00, 1'b0, "zeros");
    chk("zeros.locked", 32'(locked), 32'd0);

    // Randomized mix of good words, corruption, gaps and clears
    do_reset();
    g = LFSR_SEED;
    for (int i = 0; i < 600; i++) begin
      logic v;
      logic c;
      logic [4:0] d;
      v = ($urandom_range(0, 9) != 0);
      c = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 59) == 0) g = 5'($urandom_range(1, 31));
      if ($urandom_range(0, 7) == 0) d = 5'($urandom);
      else d = g;
      if (v) g = lfsr5_next(g);
      step(v, d, c, "rand");
    end

    // Asynchronous reset while locked with two errors
    do_reset();
    lock_seq("mid");
    step(1'b1, 5'h00, 1'b0, "mid_err");
    step(1'b1, 5'h00, 1'b0, "mid_err");
    chk("mid.pre_count", 32'(err_count), 32'd2);
    chk("mid.pre_locked", 32'(locked), 32'd1);
    #2;
    nreset = 1'b0;
    #1;
    chk("mid.locked", 32'(locked), 32'd0);
    chk("mid.count", 32'(err_count), 32'd0);
    chk("mid.expected", 32'(expected), 32'h1f);
    model_reset();
    @(negedge clk);
    nreset = 1'b1;
    step(1'b1, lfsr5_next(5'h0c), 1'b0, "mid_after");
    chk("mid.no_relock", 32'(locked), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lfsr5_checker.md
Name: lfsr5_checker

Overview:
- Downstream consumer of the 5-bit LFSR pattern generator. Samples its 5-bit output stream and locks onto the sequence.
- Once locked, predicts each next word and flags and counts mismatches. Declares loss of lock after repeated misses.
- Sits between the generator (or the DUT path it drives) and status/scoreboard logic. Used as an on-chip PRBS integrity check.

Parameters:
- LOCK_CNT, 4, consecutive correct transitions required in HUNT before asserting lock (>=1)
- LOSS_CNT, 3, consecutive mismatches in LOCKED that drop lock (>=1)
- ERR_W, 16, width of the saturating error counter

Ports:
- clk  input  1  clock, all state on rising edge
- nreset  input  1  asynchronous active-low reset
- in_valid  input  1  in_data carries a sample this cycle
- in_data  input  5  LFSR word under test
- clr_errs  input  1  synchronous clear of err_count
- locked  output  1  checker is in LOCKED state
- err_pulse  output  1  one-cycle pulse per mismatch counted in LOCKED
- err_count  output  ERR_W  saturating mismatch count
- expected  output  5  prediction for the next valid sample; meaningful only when locked=1

Behaviour:
- Interface: single clock clk; reset nreset is asynchronous, active-low.
- Next-state function f(d), with n = f(d):
  - n4 = d4^d1
  - n3 = d3^d0
  - n2 = d2^n4
  - n1 = d1^n3
  - n0 = d0^n2
  - 5'h00 maps to itself (lockup word).
  - Generator seed is 5'h1f, giving the sequence 1f, 06, 12, 02, 17, 0c, 0f, ...
- Reset values:
  - state=HUNT; locked=0, err_pulse=0, err_count=0, expected=5'h1f.
  - Internal: prev=0, prev_ok=0, match_cnt=0, miss_cnt=0.
- Only cycles with in_valid=1 advance anything. With in_valid=0, all state holds and err_pulse=0.
- All outputs are registered. Each sample's effect on locked/err_pulse/err_count/expected is visible the cycle after it is taken (latency 1).
- HUNT:
  - Each sample: prev<=in_data; prev_ok<=1.
  - Match when prev_ok=1, in_data==f(prev), and in_data!=0. On match, match_cnt++. Anything else sets match_cnt<=0.
  - A 5'h00 sample is never a match.
  - When a match makes match_cnt reach LOCK_CNT: go to LOCKED, locked<=1, expected<=f(in_data), miss_cnt<=0.
  - No errors are counted in HUNT.
- LOCKED:
  - Each sample: compare in_data with expected; always expected<=f(expected) (flywheel, no resync to input).
  - Match: miss_cnt<=0.
  - Mismatch:
    - err_pulse<=1.
    - err_count<=err_count+1, saturating at all-ones.
    - miss_cnt++.
    - If miss_cnt reaches LOSS_CNT: go to HUNT, locked<=0, match_cnt<=0, prev_ok<=0. The error is still counted.
- clr_errs:
  - Forces err_count<=0 and takes priority over a same-cycle increment; that error is not counted.
  - err_pulse still fires for that error.
  - Does not affect the state machine.
- Saturation: at 2^ERR_W-1, further mismatches keep the count and still pulse err_pulse.
- Reset mid-operation: immediate return to reset values regardless of state; relock requires a full HUNT sequence.

Decomposition:
- lfsr5_pkg holds:
  - LFSR_W=5 and LFSR_SEED=5'h1f.
  - Function lfsr5_next(d) implementing f; shared with the generator's model and the bench.
  - Enum chk_state_t {HUNT, LOCKED}.
- No sub-module. One FSM with counters; f is a package function, not a separate instance.

Test Plan:
- Clean lock: after reset, drive valid samples 1f,06,12,02,17 back-to-back -> locked=1 the cycle after 17, expected=0c, err_count=0, no err_pulse.
- Single error: locked, expecting 0c; drive 00 then 0f -> err_pulse high exactly one cycle, err_count=1, locked stays 1, second sample matches (expected then f(0f)).
- Loss of lock: locked; drive three samples of 1f -> err_pulse on each, err_count=3, locked=0 after the third; then a correct sequence 1f,06,12,02,17 relocks.
- Valid gaps and lockup: in HUNT, interleave in_valid=0 cycles between 1f,06,12,02,17 -> lock on the same sample as back-to-back. Separately, a stream of 00,00,00,00,00 never locks.
- Saturation and clear: ERR_W=2, locked, LOSS_CNT=8; drive 5 wrong samples -> err_count sticks at 3 with 5 pulses. Assert clr_errs with a 6th error -> err_count=0.
- Reset mid-lock: locked with err_count=2; pulse nreset low asynchronously between clock edges -> locked=0, err_count=0, expected=1f immediately, without waiting for a clock edge.
